// File: rtl/addr_calc_arb.sv
// addr_calc_arb: single-job address generator for NUM_CH accelerator channels.
// One channel at a time owns the buffer; its read and write streams share one
// registered address bus, alternating when both are ready.
module addr_calc_arb #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] filesize,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] rd_pause,
    input  logic [NUM_CH-1:0] wr_pause,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic [CH_W-1:0]   grant_ch,
    output logic              grant_wr,
    output logic [NUM_CH-1:0] rd_done,
    output logic [NUM_CH-1:0] wr_done,
    output logic              busy
);

    localparam int CNT_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   act, pick_ch;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  words, rd_cnt, wr_cnt;
    logic [CNT_W-1:0]  rd_cnt_nxt, wr_cnt_nxt;
    logic              ptr_wr;
    logic              any_en, act_en;
    logic              rd_req_p0, wr_req_p0, gnt_p0, dir_p0;
    logic              rd_fin_p0, wr_fin_p0;

    // Byte address of word cnt inside the buffer; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [CNT_W-1:0]  c);
        return b + {c, 2'b00};
    endfunction

    // Lowest-index enabled channel wins a new job.
    always_comb begin
        pick_ch = '0;
        any_en  = |ch_enable;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i]) pick_ch = CH_W'(i);
        end
    end

    // Stage p0: request, arbitration and next counter values for the active job.
    always_comb begin
        act_en     = ch_enable[act];
        rd_req_p0  = (state == RUN) && act_en && !rd_pause[act] && (rd_cnt < words);
        wr_req_p0  = (state == RUN) && act_en && !wr_pause[act] && (wr_cnt < words);
        gnt_p0     = rd_req_p0 || wr_req_p0;
        dir_p0     = (rd_req_p0 && wr_req_p0) ? ptr_wr : wr_req_p0;
        rd_cnt_nxt = (gnt_p0 && !dir_p0) ? rd_cnt + CNT_ONE : rd_cnt;
        wr_cnt_nxt = (gnt_p0 &&  dir_p0) ? wr_cnt + CNT_ONE : wr_cnt;
        rd_fin_p0  = (rd_cnt_nxt == words);
        wr_fin_p0  = (wr_cnt_nxt == words);
    end

    // Next-state logic; other channels never preempt a running job.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_en) state_nxt = RUN;
            RUN: begin
                if (!act_en)                     state_nxt = IDLE;
                else if (rd_fin_p0 && wr_fin_p0) state_nxt = FINISH;
            end
            FINISH:  if (!act_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stage p1: job registers, counters, done flags and the registered beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            act        <= '0;
            base       <= '0;
            words      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            ptr_wr     <= 1'b0;
            addr       <= '0;
            addr_valid <= 1'b0;
            grant_ch   <= '0;
            grant_wr   <= 1'b0;
            rd_done    <= '0;
            wr_done    <= '0;
        end else begin
            addr_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_en) begin
                        act    <= pick_ch;
                        base   <= offset;
                        words  <= filesize[ADDR_W-1:2];
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        ptr_wr <= 1'b0;
                    end
                end
                RUN: begin
                    if (!act_en) begin
                        rd_cnt       <= '0;
                        wr_cnt       <= '0;
                        rd_done[act] <= 1'b0;
                        wr_done[act] <= 1'b0;
                    end else begin
                        rd_cnt <= rd_cnt_nxt;
                        wr_cnt <= wr_cnt_nxt;
                        if (rd_fin_p0) rd_done[act] <= 1'b1;
                        if (wr_fin_p0) wr_done[act] <= 1'b1;
                        if (gnt_p0) begin
                            addr       <= beat_addr(base, dir_p0 ? wr_cnt : rd_cnt);
                            addr_valid <= 1'b1;
                            grant_ch   <= act;
                            grant_wr   <= dir_p0;
                            ptr_wr     <= !dir_p0;
                        end
                    end
                end
                FINISH: begin
                    if (!act_en) begin
                        rd_done[act] <= 1'b0;
                        wr_done[act] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_addr_calc_arb.sv
// Directed bench for addr_calc_arb: basic job, pause, priority, zero size,
// address wrap, abort and mid-job reset, all with hand-computed expectations.
module tb_addr_calc_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] offset, filesize;
    logic [2:0]  ch_enable, rd_pause, wr_pause;
    logic [31:0] addr;
    logic        addr_valid;
    logic [1:0]  grant_ch;
    logic        grant_wr;
    logic [2:0]  rd_done, wr_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    addr_calc_arb #(.NUM_CH(3), .ADDR_W(32), .CH_W(2)) dut (
        .clk(clk), .reset(reset), .offset(offset), .filesize(filesize),
        .ch_enable(ch_enable), .rd_pause(rd_pause), .wr_pause(wr_pause),
        .addr(addr), .addr_valid(addr_valid), .grant_ch(grant_ch),
        .grant_wr(grant_wr), .rd_done(rd_done), .wr_done(wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [31:0] ea, input logic [1:0] ec,
                        input logic ew);
        chk({tag, "_valid"}, 64'(addr_valid), 64'd1);
        chk({tag, "_addr"},  64'(addr),       64'(ea));
        chk({tag, "_ch"},    64'(grant_ch),   64'(ec));
        chk({tag, "_wr"},    64'(grant_wr),   64'(ew));
    endtask

    task automatic idle_beat(input string tag);
        chk({tag, "_valid"}, 64'(addr_valid), 64'd0);
    endtask

    task automatic done_chk(input string tag, input logic [2:0] er, input logic [2:0] ew,
                            input logic eb);
        chk({tag, "_rd_done"}, 64'(rd_done), 64'(er));
        chk({tag, "_wr_done"}, 64'(wr_done), 64'(ew));
        chk({tag, "_busy"},    64'(busy),    64'(eb));
    endtask

    initial begin
        reset = 1'b1; offset = '0; filesize = '0;
        ch_enable = '0; rd_pause = '0; wr_pause = '0;

        // Reset values
        step(); step();
        idle_beat("rst");
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_ch", 64'(grant_ch), 64'd0);
        chk("rst_wr", 64'(grant_wr), 64'd0);
        done_chk("rst", 3'b000, 3'b000, 1'b0);
        reset = 1'b0;
        step();

        // Basic job: 4 words, alternating R/W starting with read
        offset = 32'h1000; filesize = 32'd16; ch_enable = 3'b001;
        step();
        idle_beat("basic_entry");
        chk("basic_busy", 64'(busy), 64'd1);
        offset = 32'h5000; filesize = 32'd64;   // must be ignored mid-job
        for (int i = 0; i < 8; i++) begin
            step();
            beat($sformatf("basic_b%0d", i), 32'h1000 + 32'((i / 2) * 4), 2'd0, 1'(i % 2));
            if (i == 6) done_chk("basic_rd_first", 3'b001, 3'b000, 1'b1);
        end
        done_chk("basic_end", 3'b001, 3'b001, 1'b1);
        step();
        idle_beat("basic_finish");
        chk("basic_hold_addr", 64'(addr), 64'h100C);
        chk("basic_hold_wr", 64'(grant_wr), 64'd1);
        done_chk("basic_finish", 3'b001, 3'b001, 1'b1);
        ch_enable = 3'b000;
        step();
        done_chk("basic_idle", 3'b000, 3'b000, 1'b0);

        // Write stream paused: reads run back to back
        offset = 32'h1000; filesize = 32'd16; ch_enable = 3'b001; wr_pause = 3'b001;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            beat($sformatf("pause_r%0d", i), 32'h1000 + 32'(i * 4), 2'd0, 1'b0);
        end
        done_chk("pause_rd", 3'b001, 3'b000, 1'b1);
        step();
        idle_beat("pause_stall");
        chk("pause_wr_done", 64'(wr_done), 64'd0);
        wr_pause = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            beat($sformatf("pause_w%0d", i), 32'h1000 + 32'(i * 4), 2'd0, 1'b1);
        end
        done_chk("pause_end", 3'b001, 3'b001, 1'b1);
        ch_enable = 3'b000;
        step();
        done_chk("pause_idle", 3'b000, 3'b000, 1'b0);

        // Priority and no preemption
        offset = 32'h2000; filesize = 32'd8; ch_enable = 3'b110;
        step();
        step();
        beat("prio_b0", 32'h2000, 2'd1, 1'b0);
        ch_enable = 3'b111;
        step(); beat("prio_b1", 32'h2000, 2'd1, 1'b1);
        step(); beat("prio_b2", 32'h2004, 2'd1, 1'b0);
        step(); beat("prio_b3", 32'h2004, 2'd1, 1'b1);
        done_chk("prio_done", 3'b010, 3'b010, 1'b1);
        step();
        idle_beat("prio_finish");
        ch_enable = 3'b001;
        step();
        done_chk("prio_idle", 3'b000, 3'b000, 1'b0);
        step();
        step();
        beat("prio_ch0", 32'h2000, 2'd0, 1'b0);
        ch_enable = 3'b000;
        step();
        idle_beat("prio_abort");
        done_chk("prio_abort", 3'b000, 3'b000, 1'b0);

        // Zero size: done immediately, no beats
        offset = 32'h3000; filesize = 32'd3; ch_enable = 3'b001;
        step();
        done_chk("zero_entry", 3'b000, 3'b000, 1'b1);
        step();
        idle_beat("zero_run");
        done_chk("zero_done", 3'b001, 3'b001, 1'b1);
        step();
        idle_beat("zero_finish");
        ch_enable = 3'b000;
        step();
        done_chk("zero_idle", 3'b000, 3'b000, 1'b0);

        // Address wrap at top of space
        offset = 32'hFFFF_FFFC; filesize = 32'd8; ch_enable = 3'b001;
        step();
        step(); beat("wrap_b0", 32'hFFFF_FFFC, 2'd0, 1'b0);
        step(); beat("wrap_b1", 32'hFFFF_FFFC, 2'd0, 1'b1);
        step(); beat("wrap_b2", 32'h0000_0000, 2'd0, 1'b0);
        step(); beat("wrap_b3", 32'h0000_0000, 2'd0, 1'b1);
        ch_enable = 3'b000;
        step();

        // Abort after 3 beats clears the read done flag already set
        offset = 32'h1000; filesize = 32'd8; ch_enable = 3'b001;
        step();
        step(); beat("abort_b0", 32'h1000, 2'd0, 1'b0);
        step(); beat("abort_b1", 32'h1000, 2'd0, 1'b1);
        step(); beat("abort_b2", 32'h1004, 2'd0, 1'b0);
        done_chk("abort_pre", 3'b001, 3'b000, 1'b1);
        ch_enable = 3'b000;
        step();
        idle_beat("abort_e1");
        done_chk("abort_e1", 3'b000, 3'b000, 1'b0);
        step();
        idle_beat("abort_e2");
        chk("abort_e2_busy", 64'(busy), 64'd0);

        // Reset mid-job, then first beat on the second edge after release
        offset = 32'h1000; filesize = 32'd16; ch_enable = 3'b001;
        step();
        step(); beat("mrst_b0", 32'h1000, 2'd0, 1'b0);
        step(); beat("mrst_b1", 32'h1000, 2'd0, 1'b1);
        reset = 1'b1;
        step();
        idle_beat("mrst");
        chk("mrst_addr", 64'(addr), 64'd0);
        chk("mrst_ch", 64'(grant_ch), 64'd0);
        chk("mrst_wr", 64'(grant_wr), 64'd0);
        done_chk("mrst", 3'b000, 3'b000, 1'b0);
        reset = 1'b0;
        step();
        idle_beat("mrst_rel1");
        chk("mrst_rel1_busy", 64'(busy), 64'd1);
        step();
        beat("mrst_rel2", 32'h1000, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
